// File: rtl/press_classifier.sv
// Classifies debounced button gestures as short, long or double presses and
// counts press (0->1) events. All outputs are registered.
module press_classifier #(
   parameter int                    TIMER_SIZE = 16,
   parameter logic [TIMER_SIZE-1:0] LONG_LIMIT = 16'd50000,
   parameter logic [TIMER_SIZE-1:0] GAP_LIMIT  = 16'd15000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in,
   output logic       short_press,
   output logic       long_press,
   output logic       double_press,
   output logic       held,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      GAP       = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   state_t                  state_reg, state_next;
   logic [TIMER_SIZE-1:0]   timer_reg, timer_next;
   logic                    short_next, long_next, double_next, held_next;
   logic [7:0]              count_next;

   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      short_next  = 1'b0;
      long_next   = 1'b0;
      double_next = 1'b0;
      held_next   = held;
      count_next  = press_count;
      case (state_reg)
         IDLE: begin
            if (in) begin
               state_next = PRESS1;
               timer_next = '0;
               count_next = press_count + 8'd1;
            end
         end
         PRESS1: begin
            // A release on the LONG_LIMIT edge still counts as a short gesture.
            if (!in) begin
               state_next = GAP;
               timer_next = '0;
            end else if (timer_reg == LONG_LIMIT) begin
               state_next = LONG_HELD;
               long_next  = 1'b1;
               held_next  = 1'b1;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!in) begin
               state_next = IDLE;
               held_next  = 1'b0;
            end
         end
         GAP: begin
            // A second press wins over the timeout on the GAP_LIMIT edge.
            if (in) begin
               state_next = PRESS2;
               count_next = press_count + 8'd1;
            end else if (timer_reg == GAP_LIMIT) begin
               state_next = IDLE;
               short_next = 1'b1;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         PRESS2: begin
            if (!in) begin
               state_next  = IDLE;
               double_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
            held_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         timer_reg    <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_press <= 1'b0;
         held         <= 1'b0;
         press_count  <= 8'd0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         short_press  <= short_next;
         long_press   <= long_next;
         double_press <= double_next;
         held         <= held_next;
         press_count  <= count_next;
      end
   end

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: stimulus queues expected pulses with
// their cycle, a negedge monitor pops and compares each pulse the DUT emits.
module tb_press_classifier;

   localparam logic [15:0] LONG_L = 16'd20;
   localparam logic [15:0] GAP_L  = 16'd10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in    = 1'b0;
   logic       short_press, long_press, double_press, held;
   logic [7:0] press_count;

   press_classifier #(
      .TIMER_SIZE (16),
      .LONG_LIMIT (LONG_L),
      .GAP_LIMIT  (GAP_L)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in           (in),
      .short_press  (short_press),
      .long_press   (long_press),
      .double_press (double_press),
      .held         (held),
      .press_count  (press_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int kind;   // 0 short, 1 long, 2 double
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pc     = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_pulse(input int kind, input int at);
      exp_t e;
      e.kind = kind;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   // Pulse monitor
   int   mon_n;
   int   mon_kind;
   exp_t mon_e;
   always @(negedge clock) begin
      if (!reset) begin
         mon_n = int'(short_press) + int'(long_press) + int'(double_press);
         if (mon_n != 0) begin
            mon_kind = short_press ? 0 : (long_press ? 1 : 2);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: got kind %0d (count %0d) at cycle %0d, expected none",
                        mon_kind, mon_n, cyc);
            end else begin
               mon_e = sb.pop_front();
               if (mon_n != 1 || mon_e.kind != mon_kind || mon_e.cyc != cyc) begin
                  errors++;
                  $display("FAIL pulse: got kind %0d x%0d at cycle %0d, expected kind %0d at cycle %0d",
                           mon_kind, mon_n, cyc, mon_e.kind, mon_e.cyc);
               end else begin
                  $display("ok   pulse kind %0d at cycle %0d", mon_kind, cyc);
               end
            end
         end
      end
   end

   initial begin
      // 1: reset and idle
      step(3);
      check_val("reset_pulses", int'({short_press, long_press, double_press}), 0);
      check_val("reset_held", int'(held), 0);
      check_val("reset_count", int'(press_count), 0);
      reset = 1'b0;
      step(100);
      check_val("idle_count", int'(press_count), 0);

      // 2: short press
      in = 1'b1; step(5);
      in = 1'b0; expect_pulse(0, cyc + 1 + int'(GAP_L) + 1);
      step(30);
      pc++;
      check_val("short_count", int'(press_count), pc);

      // 3: long press and held level
      in = 1'b1; expect_pulse(1, cyc + 1 + int'(LONG_L) + 1);
      step(30);
      check_val("held_during", int'(held), 1);
      in = 1'b0;
      check_val("held_before_release_edge", int'(held), 1);
      step(1);
      check_val("held_after_release", int'(held), 0);
      step(30);
      pc++;
      check_val("long_count", int'(press_count), pc);

      // 4: double press
      in = 1'b1; step(5);
      in = 1'b0; step(4);
      in = 1'b1; step(5);
      in = 1'b0; expect_pulse(2, cyc + 1);
      step(30);
      pc += 2;
      check_val("double_count", int'(press_count), pc);

      // 5a: gap of exactly GAP_L+1 low samples -> double
      in = 1'b1; step(3);
      in = 1'b0; step(int'(GAP_L) + 1);
      in = 1'b1; step(3);
      in = 1'b0; expect_pulse(2, cyc + 1);
      step(20);
      pc += 2;
      check_val("gap_edge_double_count", int'(press_count), pc);

      // 5b: gap of GAP_L+2 low samples -> short, then a fresh press
      in = 1'b1; step(3);
      in = 1'b0; expect_pulse(0, cyc + int'(GAP_L) + 2);
      step(int'(GAP_L) + 2);
      in = 1'b1; step(3);
      pc += 2;
      check_val("gap_over_short_count", int'(press_count), pc);
      in = 1'b0; expect_pulse(0, cyc + int'(GAP_L) + 2);
      step(20);
      check_val("second_short_count", int'(press_count), pc);

      // 6: reset mid-hold discards the gesture
      in = 1'b1; step(10);
      reset = 1'b1; #1;
      check_val("midreset_pulses", int'({short_press, long_press, double_press}), 0);
      check_val("midreset_held", int'(held), 0);
      check_val("midreset_count", int'(press_count), 0);
      in = 1'b0; step(2);
      reset = 1'b0;
      step(30);
      pc = 0;
      check_val("post_reset_count", int'(press_count), pc);

      // 256 short presses wrap the counter
      for (int i = 0; i < 256; i++) begin
         in = 1'b1; step(2);
         in = 1'b0; expect_pulse(0, cyc + int'(GAP_L) + 2);
         step(int'(GAP_L) + 3);
         pc = (pc + 1) % 256;
         if (i == 254) check_val("count_255", int'(press_count), pc);
      end
      check_val("count_wrap", int'(press_count), pc);

      step(20);
      check_val("pending_pulses", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
